// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter for a byte-wide memory/IO
// bus. Each access runs IDLE -> ACCESS -> DONE. A locked owner may chain up to
// MAX_BURST consecutive accesses without giving up the bus.
//
// Handshake: a requester holds reqN (with weN/addrN/wdataN stable) until it
// sees gntN. Its access is latched at the grant edge. doneN pulses for exactly
// one cycle when that access completes. rdata is valid with doneN for reads.
// A requester that wants another access without losing the bus holds reqN and
// lockN high during the DONE cycle, with the new addr/we/wdata already on its
// inputs.
`timescale 1ns/1ps

module mem_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [18:0] addr0,
    input  logic [18:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rdata,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Index of the last access in a burst; the counter holds the number of
    // accesses already chained after the first one of the current grant.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t      state_q,  state_d;
    logic        owner_q,  owner_d;   // 0 = requester 0, 1 = requester 1
    logic        ptr_q,    ptr_d;     // last requester that held the bus
    logic [3:0]  burst_q,  burst_d;
    logic [18:0] addr_q,   addr_d;
    logic        we_q,     we_d;
    logic [7:0]  wdata_q,  wdata_d;
    logic [7:0]  rdata_q,  rdata_d;

    logic        win_sel;
    logic        pick;
    logic        pick_req;
    logic        pick_lock;
    logic        pick_we;
    logic [18:0] pick_addr;
    logic [7:0]  pick_wdata;

    // Round-robin winner for an IDLE arbitration: a lone requester wins,
    // on a tie the requester that did not hold the bus last wins.
    always_comb begin
        win_sel = 1'b0;
        if (req0 && req1) begin
            win_sel = ~ptr_q;
        end else if (req1) begin
            win_sel = 1'b1;
        end
    end

    // Source of the next latched access: the arbitration winner in IDLE,
    // otherwise the current owner (burst continuation from DONE).
    always_comb begin
        pick       = (state_q == IDLE) ? win_sel : owner_q;
        pick_req   = pick ? req1   : req0;
        pick_lock  = pick ? lock1  : lock0;
        pick_we    = pick ? we1    : we0;
        pick_addr  = pick ? addr1  : addr0;
        pick_wdata = pick ? wdata1 : wdata0;
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = win_sel;
                    addr_d  = pick_addr;
                    we_d    = pick_we;
                    wdata_d = pick_wdata;
                    burst_d = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Inputs are ignored here; the latched access always finishes.
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = DONE;
            end
            DONE: begin
                if (pick_req && pick_lock && (burst_q < BURST_LAST)) begin
                    addr_d  = pick_addr;
                    we_d    = pick_we;
                    wdata_d = pick_wdata;
                    burst_d = burst_q + 4'd1;
                    state_d = ACCESS;
                end else begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also kills an in-flight write
    // because mem_we is decoded from state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b1;
            burst_q <= 4'd0;
            addr_q  <= 19'd0;
            we_q    <= 1'b0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode: everything is a function of registered state so that
    // reset drops gnt/done/mem_we/busy without waiting for a clock edge.
    always_comb begin
        busy      = (state_q != IDLE);
        gnt0      = busy && !owner_q;
        gnt1      = busy &&  owner_q;
        done0     = (state_q == DONE) && !owner_q;
        done1     = (state_q == DONE) &&  owner_q;
        mem_we    = (state_q == ACCESS) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
        state_dbg = state_q;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL provide parameter MAX_BURST, default 4, giving the maximum consecutive locked accesses per grant (range 1..15).
REQ-002 SHALL provide port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports req0/req1  input  1 each  access request from requester 0/1.
REQ-005 SHALL provide ports we0/we1  input  1 each  1 = write, 0 = read.
REQ-006 SHALL provide ports addr0/addr1  input  19 each  byte address.
REQ-007 SHALL provide ports wdata0/wdata1  input  8 each  write data.
REQ-008 SHALL provide ports lock0/lock1  input  1 each  request to keep ownership for a following access.
REQ-009 SHALL provide ports gnt0/gnt1  output  1 each  bus ownership indication.
REQ-010 SHALL provide ports done0/done1  output  1 each  one-cycle completion strobe.
REQ-011 SHALL provide port rdata  output  8  read data shared by both requesters, valid with done.
REQ-012 SHALL provide ports mem_addr  output 19, mem_we  output 1, mem_wdata  output 8, mem_rdata  input 8  to the memory/IO bus (combinational read, write on clock edge while mem_we=1).
REQ-013 SHALL provide port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACCESS, DONE; at most one requester owns the bus at a time.
REQ-015 In IDLE with exactly one req high, that requester SHALL win; with both high, the requester not equal to the last-granted pointer SHALL win (round-robin).
REQ-016 On a win, the arbiter SHALL latch the winner's addr/we/wdata, assert its gnt, clear the burst counter, and enter ACCESS on the next cycle.
REQ-017 In ACCESS (exactly one cycle), mem_addr/mem_wdata SHALL carry the latched values and mem_we SHALL equal the latched we; mem_we SHALL be 0 in every other state.
REQ-018 At the end of a read ACCESS, rdata SHALL capture mem_rdata; on writes rdata SHALL hold its prior value.
REQ-019 In DONE, the owner's done SHALL be high for exactly one cycle; gnt SHALL stay high through DONE.
REQ-020 In DONE, if the owner's req and lock are both high and burst counter < MAX_BURST-1, the arbiter SHALL latch the owner's new request, increment the counter, and return to ACCESS without releasing gnt.
REQ-021 Otherwise, in DONE, gnt SHALL drop at the next edge, the pointer SHALL update to the owner, and the state SHALL return to IDLE.
REQ-022 Latency: req sampled high in IDLE at edge N -> gnt high and ACCESS during cycle N+1 -> done high during cycle N+2; unlocked accesses occupy 3 cycles.
REQ-023 Changes to the owner's req/addr/we/wdata during ACCESS SHALL be ignored; the latched access SHALL complete.
REQ-024 When the burst limit is reached with the other requester waiting, the other SHALL win the next IDLE arbitration; with no other requester, the same requester SHALL re-win.
REQ-025 mem_addr SHALL hold its last value outside ACCESS; a non-owner's requests SHALL never drive the bus.

Reset
REQ-026 While reset is high: state IDLE, gnt0=gnt1=0, done0=done1=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, burst counter 0, pointer=1 (requester 0 wins first tie).
REQ-027 Reset asserted mid-ACCESS SHALL force mem_we low immediately (asynchronously); the interrupted write is not guaranteed to complete and no done SHALL be issued.

Verification
REQ-028 Read: req0=1, we0=0, addr0=0x3fd00, mem_rdata=0x71 -> gnt0 at N+1, mem_addr=0x3fd00, mem_we=0, done0 at N+2 with rdata=0x71.
REQ-029 Tie: req0=req1=1 continuously after reset, no lock -> grants alternate 0,1,0,1; each done exactly 3 cycles apart per access.
REQ-030 Write: req1=1, we1=1, addr1=0x3f201, wdata1=0x48 -> mem_we high exactly one cycle with mem_addr=0x3f201, mem_wdata=0x48; rdata unchanged.
REQ-031 Burst: lock0=1, req0 held for 6 accesses, req1 pending -> four consecutive req0 accesses (gnt0 continuous), then one req1 access, then remaining req0 accesses.
REQ-032 Reset during write ACCESS to 0x3f900 -> mem_we, gnt, busy low without a clock edge; after release, tie is won by requester 0.
